// File: rtl/axil_rd_arbiter_if.sv
// AXI-lite read bundle: S_COUNT requester lanes plus one shared master lane.
// slave modport is the arbiter's view; master modport is the environment's.
interface axil_rd_arbiter_if #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [S_COUNT*ADDR_WIDTH-1:0] s_axil_araddr;
  logic [S_COUNT*3-1:0]          s_axil_arprot;
  logic [S_COUNT-1:0]            s_axil_arvalid;
  logic [S_COUNT-1:0]            s_axil_arready;
  logic [S_COUNT*DATA_WIDTH-1:0] s_axil_rdata;
  logic [S_COUNT*2-1:0]          s_axil_rresp;
  logic [S_COUNT-1:0]            s_axil_rvalid;
  logic [S_COUNT-1:0]            s_axil_rready;
  logic [ADDR_WIDTH-1:0]         m_axil_araddr;
  logic [2:0]                    m_axil_arprot;
  logic                          m_axil_arvalid;
  logic                          m_axil_arready;
  logic [DATA_WIDTH-1:0]         m_axil_rdata;
  logic [1:0]                    m_axil_rresp;
  logic                          m_axil_rvalid;
  logic                          m_axil_rready;

  modport slave (
    input  s_axil_araddr, s_axil_arprot, s_axil_arvalid,
    output s_axil_arready,
    output s_axil_rdata, s_axil_rresp, s_axil_rvalid,
    input  s_axil_rready,
    output m_axil_araddr, m_axil_arprot, m_axil_arvalid,
    input  m_axil_arready,
    input  m_axil_rdata, m_axil_rresp, m_axil_rvalid,
    output m_axil_rready
  );

  modport master (
    output s_axil_araddr, s_axil_arprot, s_axil_arvalid,
    input  s_axil_arready,
    input  s_axil_rdata, s_axil_rresp, s_axil_rvalid,
    output s_axil_rready,
    input  m_axil_araddr, m_axil_arprot, m_axil_arvalid,
    output m_axil_arready,
    output m_axil_rdata, m_axil_rresp, m_axil_rvalid,
    input  m_axil_rready
  );
endinterface

// File: rtl/axil_rd_arbiter.sv
// Shares one AXI-lite read master among S_COUNT requesters, one read in flight.
// Ports: clk, rst (sync, high), bus (slave modport), busy, grant_index.
module axil_rd_arbiter #(
  parameter int S_COUNT         = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int ARB_ROUND_ROBIN = 1,
  localparam int GRANT_WIDTH    =
    (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  axil_rd_arbiter_if.slave       bus,
  output logic                   busy,
  output logic [GRANT_WIDTH-1:0] grant_index
);

  typedef enum logic [1:0] {
    IDLE, ADDR, DATA, RESP
  } state_t;

  state_t                        state;
  logic [GRANT_WIDTH-1:0]        last_grant;
  logic [GRANT_WIDTH-1:0]        win;
  logic                          any_req;
  int unsigned                   rr_idx;
  logic [ADDR_WIDTH-1:0]         sel_addr;
  logic [2:0]                    sel_prot;
  logic [S_COUNT-1:0]            arready;
  logic                          rready_g;
  logic [ADDR_WIDTH-1:0]         araddr_q;
  logic [2:0]                    arprot_q;
  logic                          arvalid_q;
  logic [S_COUNT*DATA_WIDTH-1:0] rdata_q;
  logic [S_COUNT*2-1:0]          rresp_q;
  logic [S_COUNT-1:0]            rvalid_q;

  // Descending scan: the last hit is the nearest index after last_grant
  // (round-robin) or the lowest index (fixed priority).
  always_comb begin
    win     = '0;
    rr_idx  = 0;
    any_req = |bus.s_axil_arvalid;
    if (ARB_ROUND_ROBIN != 0) begin
      for (int k = S_COUNT; k >= 1; k--) begin
        rr_idx = (int'(last_grant) + k) % S_COUNT;
        if (bus.s_axil_arvalid[GRANT_WIDTH'(rr_idx)])
          win = GRANT_WIDTH'(rr_idx);
      end
    end else begin
      for (int i = S_COUNT - 1; i >= 0; i--) begin
        if (bus.s_axil_arvalid[i])
          win = GRANT_WIDTH'(i);
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_prot = '0;
    arready  = '0;
    rready_g = 1'b0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (GRANT_WIDTH'(i) == win) begin
        sel_addr = bus.s_axil_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_prot = bus.s_axil_arprot[i*3 +: 3];
        arready[i] = (state == IDLE) && any_req;
      end
      if (GRANT_WIDTH'(i) == grant_index)
        rready_g = bus.s_axil_rready[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arprot_q    <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      rresp_q     <= '0;
      grant_index <= '0;
      last_grant  <= GRANT_WIDTH'(S_COUNT - 1);
    end else begin
      unique case (state)
        IDLE: if (any_req) begin
          araddr_q    <= sel_addr;
          arprot_q    <= sel_prot;
          arvalid_q   <= 1'b1;
          grant_index <= win;
          state       <= ADDR;
        end
        ADDR: if (bus.m_axil_arready) begin
          arvalid_q <= 1'b0;
          state     <= DATA;
        end
        DATA: if (bus.m_axil_rvalid) begin
          for (int i = 0; i < S_COUNT; i++) begin
            if (GRANT_WIDTH'(i) == grant_index) begin
              rdata_q[i*DATA_WIDTH +: DATA_WIDTH] <= bus.m_axil_rdata;
              rresp_q[i*2 +: 2] <= bus.m_axil_rresp;
              rvalid_q[i]       <= 1'b1;
            end
          end
          state <= RESP;
        end
        RESP: if (rready_g) begin
          rvalid_q   <= '0;
          last_grant <= grant_index;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy               = (state != IDLE);
  assign bus.s_axil_arready = arready;
  assign bus.s_axil_rdata   = rdata_q;
  assign bus.s_axil_rresp   = rresp_q;
  assign bus.s_axil_rvalid  = rvalid_q;
  assign bus.m_axil_araddr  = araddr_q;
  assign bus.m_axil_arprot  = arprot_q;
  assign bus.m_axil_arvalid = arvalid_q;
  assign bus.m_axil_rready  = (state == DATA);

endmodule
